ftdi_rx_reader: RTL and testbench
=================================

Name: ftdi_rx_reader

Overview:
Receive-direction companion to the FT232H write path. Runs the FT232H 245-synchronous-FIFO read handshake in the 60 MHz ftdi_clk domain and moves host-to-FPGA bytes into an internal DEPTH-entry buffer. The buffer is presented as an AXI-Stream source (axis_io Source modport) to downstream logic. Bus direction is arbitrated above this block via rx_grant; this block never drives ADBUS.

Parameters:
DEPTH, 4, receive buffer entries; power of two, minimum 4.
COUNT_WIDTH, 32, width of the received-byte counter.

Ports:
ftdi_clk  input  1  60 MHz FTDI clock; sole clock.
rst_n  input  1  asynchronous active-low reset.
ftdi_rxf_n  input  1  FTDI RXF#; low = host data available.
ftdi_adbus_in  input  8  ADBUS input sample.
ftdi_oe_n  output  1  FTDI OE#; registered.
ftdi_rd_n  output  1  FTDI RD#; registered.
bus_busy  output  1  high while the FTDI owns ADBUS; top level must tristate FPGA drivers.
rx_grant  input  1  arbiter permission to start or continue reading.
m_axis  Source  axis_io  tdata[7:0], tvalid, tready.
rx_count  output  COUNT_WIDTH  total bytes captured; wraps modulo 2^COUNT_WIDTH.
overflow_err  output  1  sticky; set if a capture occurs with the buffer full.

Behaviour:
- Reset (async assert, sync release): ftdi_oe_n=1, ftdi_rd_n=1, bus_busy=0, buffer empty, m_axis.tvalid=0, tdata=0, rx_count=0, overflow_err=0, state=IDLE. Reset mid-burst drops buffered bytes and raises RD#/OE# immediately.
- Capture: at a rising edge where ftdi_rd_n==0 and ftdi_rxf_n==0, write ftdi_adbus_in into the buffer and increment rx_count. No capture under any other condition.
- space_ok: buffer count after this edge's capture/pop <= DEPTH-2. Because RD# is registered, this guarantees no overflow. overflow_err firing is a design bug.
- IDLE: OE#=1, RD#=1, bus_busy=0. If rx_grant && !rxf_n && space_ok, go to OE_WAIT; OE#<=0, bus_busy<=1.
- OE_WAIT (exactly 1 cycle, RD#=1): go to READ. RD#<=0 if !rxf_n && space_ok && rx_grant.
- READ:
  - If rxf_n==1 or rx_grant==0: OE#<=1, RD#<=1, go to TURNAROUND.
  - Otherwise RD#<=!space_ok and OE# stays 0. A full buffer pauses reading without releasing the bus.
  - Capture in the same edge as exit is still valid: a byte with rd_n==0 && rxf_n==0 is kept.
- TURNAROUND (exactly 1 cycle): OE#=1, RD#=1, bus_busy=1. Then go to IDLE with bus_busy<=0.
- Latency: rxf_n sampled low in IDLE with grant gives OE# low after edge 0, RD# low after edge 1, first capture at edge 2. tvalid=1 after edge 2 (3 cycles). Sustained rate is 1 byte/cycle while tready=1 and rxf_n=0.
- AXIS buffer:
  - tvalid = (count != 0); tdata = head entry. Both are stable while tvalid && !tready.
  - Pop on tvalid && tready.
  - Simultaneous capture and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Order is strictly preserved; no byte is duplicated or dropped.
- rx_grant deasserting in OE_WAIT: RD# stays 1, and the block takes READ's exit on the next cycle.

Test Plan:
- Single byte: rxf_n low for exactly one RD# cycle, adbus=0x45, tready=1. Required: OE# low at edge 0, RD# low at edge 1, tvalid with tdata=0x45 after edge 2, rx_count=1, TURNAROUND then IDLE.
- Burst of 16 bytes 0x00..0x0F, tready=1. Required: one byte per cycle, m_axis sees 0x00..0x0F in order, rx_count=16, overflow_err=0.
- Backpressure: 16-byte burst with tready=0 for 10 cycles mid-burst. Required: RD# rises once count reaches DEPTH-2, OE# stays 0, resumes after tready, all 16 bytes in order, overflow_err=0.
- RXF# deasserts mid-burst after 5 bytes. Required: 5th byte (captured on the exit edge) kept, OE#/RD# high next cycle, one TURNAROUND cycle with bus_busy=1, then IDLE.
- rx_grant drops during READ. Required: exit within one cycle, no capture while RD#=1, restart from IDLE when grant returns and rxf_n is low.
- rst_n pulsed low mid-burst (async, between edges). Required: OE#/RD# high immediately, tvalid=0, rx_count=0, overflow_err=0 after release.

Source files
------------

// File: rtl/ftdi_rx_reader.sv
// FT232H 245-synchronous-FIFO read handshake in the ftdi_clk domain, feeding a
// small receive buffer that is drained through an AXI-Stream source.
module ftdi_rx_reader #(
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   ftdi_clk,
  input  logic                   rst_n,
  input  logic                   ftdi_rxf_n,
  input  logic [7:0]             ftdi_adbus_in,
  output logic                   ftdi_oe_n,
  output logic                   ftdi_rd_n,
  output logic                   bus_busy,
  input  logic                   rx_grant,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [COUNT_WIDTH-1:0] rx_count,
  output logic                   overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_LIMIT = LVL_W'(DEPTH - 2);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    OE_WAIT    = 2'd1,
    READ       = 2'd2,
    TURNAROUND = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   oe_n_d, rd_n_d, busy_d;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level_q, level_d;
  logic             capture, pop, full, wr_en, space_ok;

  // RD# is registered, so the byte on ADBUS is taken whenever the FTDI sees RD# low
  // with data present, regardless of which state we are in.
  assign capture  = !ftdi_rd_n && !ftdi_rxf_n;
  assign full     = (level_q == LVL_FULL);
  assign pop      = m_axis_tvalid && m_axis_tready;
  assign wr_en    = capture && (!full || pop);
  assign space_ok = (level_d <= LVL_LIMIT);

  assign m_axis_tvalid = (level_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : 8'h00;

  always_comb begin
    level_d = level_q;
    if (wr_en && !pop)
      level_d = level_q + 1'b1;
    else if (!wr_en && pop)
      level_d = level_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    oe_n_d  = ftdi_oe_n;
    rd_n_d  = ftdi_rd_n;
    busy_d  = bus_busy;
    case (state_q)
      IDLE: begin
        oe_n_d = 1'b1;
        rd_n_d = 1'b1;
        busy_d = 1'b0;
        if (rx_grant && !ftdi_rxf_n && space_ok) begin
          state_d = OE_WAIT;
          oe_n_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      OE_WAIT: begin
        state_d = READ;
        rd_n_d  = !(!ftdi_rxf_n && space_ok && rx_grant);
      end
      READ: begin
        if (ftdi_rxf_n || !rx_grant) begin
          state_d = TURNAROUND;
          oe_n_d  = 1'b1;
          rd_n_d  = 1'b1;
        end else begin
          // A nearly full buffer pauses RD# but keeps the bus owned.
          rd_n_d = !space_ok;
        end
      end
      TURNAROUND: begin
        state_d = IDLE;
        oe_n_d  = 1'b1;
        rd_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        oe_n_d  = 1'b1;
        rd_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ftdi_oe_n <= 1'b1;
      ftdi_rd_n <= 1'b1;
      bus_busy  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ftdi_oe_n <= oe_n_d;
      ftdi_rd_n <= rd_n_d;
      bus_busy  <= busy_d;
    end
  end

  always_ff @(posedge ftdi_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_q      <= '0;
      rx_count     <= '0;
      overflow_err <= 1'b0;
    end else begin
      level_q <= level_d;
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (capture)
        rx_count <= rx_count + 1'b1;
      if (capture && full && !pop)
        overflow_err <= 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge ftdi_clk) begin
    if (wr_en)
      mem[wr_ptr] <= ftdi_adbus_in;
  end

endmodule

// File: tb/tb_ftdi_rx_reader.sv
// Directed bench for ftdi_rx_reader: a simple FT232H host model supplies bytes and
// every AXI-Stream pop is compared in order against the bytes the host sent.
module tb_ftdi_rx_reader;

  localparam int DEPTH = 4;
  localparam int CW    = 32;

  logic          ftdi_clk      = 1'b0;
  logic          rst_n         = 1'b0;
  logic          ftdi_rxf_n    = 1'b1;
  logic [7:0]    ftdi_adbus_in = 8'h00;
  logic          rx_grant      = 1'b0;
  logic          m_axis_tready = 1'b0;
  logic          ftdi_oe_n, ftdi_rd_n, bus_busy;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tvalid;
  logic [CW-1:0] rx_count;
  logic          overflow_err;

  ftdi_rx_reader #(.DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
    .ftdi_clk      (ftdi_clk),
    .rst_n         (rst_n),
    .ftdi_rxf_n    (ftdi_rxf_n),
    .ftdi_adbus_in (ftdi_adbus_in),
    .ftdi_oe_n     (ftdi_oe_n),
    .ftdi_rd_n     (ftdi_rd_n),
    .bus_busy      (bus_busy),
    .rx_grant      (rx_grant),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .rx_count      (rx_count),
    .overflow_err  (overflow_err)
  );

  always #5 ftdi_clk = ~ftdi_clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] host_data [32];
  int         host_idx   = 0;
  int         host_avail = 0;
  int         rcv_cnt    = 0;
  int         cyc        = 0;
  int         first_cap  = 0;
  int         last_cap   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic host_drive();
    ftdi_rxf_n    = (host_idx >= host_avail);
    ftdi_adbus_in = (host_idx < host_avail) ? host_data[host_idx] : 8'h00;
  endtask

  task automatic start_burst(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) host_data[i] = base + 8'(i);
    host_idx   = 0;
    host_avail = n;
    rcv_cnt    = 0;
    host_drive();
  endtask

  // One clock: sample handshakes at the falling edge, act on them just after the rising edge.
  task automatic step();
    logic       cap, pop;
    logic [7:0] d;
    @(negedge ftdi_clk);
    cap = !ftdi_rd_n && !ftdi_rxf_n;
    pop = m_axis_tvalid && m_axis_tready;
    d   = m_axis_tdata;
    @(posedge ftdi_clk);
    #1;
    cyc++;
    if (cap) begin
      if (host_idx == 0) first_cap = cyc;
      last_cap = cyc;
      host_idx++;
      host_drive();
    end
    if (pop) begin
      if (rcv_cnt < host_avail)
        check($sformatf("byte%0d", rcv_cnt), {24'h0, d}, {24'h0, host_data[rcv_cnt]});
      else
        check("extra_byte", 32'(rcv_cnt), 32'(host_avail - 1));
      rcv_cnt++;
    end
  endtask

  task automatic run_until_done(input int max_cycles, input string tag);
    bit done = 0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      step();
      done = (host_idx == host_avail) && (rcv_cnt == host_avail) && !bus_busy;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic step_until_sent(input int n, input int max_cycles, input string tag);
    for (int i = 0; i < max_cycles && host_idx < n; i++) step();
    check({tag, "_sent"}, 32'(host_idx), 32'(n));
  endtask

  initial begin
    #12;
    check("rst_oe_n", 32'(ftdi_oe_n), 32'd1);
    check("rst_rd_n", 32'(ftdi_rd_n), 32'd1);
    check("rst_busy", 32'(bus_busy), 32'd0);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_count", rx_count, 32'd0);
    check("rst_ovf", 32'(overflow_err), 32'd0);
    @(posedge ftdi_clk);
    #1;
    rst_n = 1'b1;
    step();

    // Single byte
    rx_grant      = 1'b1;
    m_axis_tready = 1'b1;
    start_burst(1, 8'h45);
    step();
    check("single_e0_oe", 32'(ftdi_oe_n), 32'd0);
    check("single_e0_rd", 32'(ftdi_rd_n), 32'd1);
    check("single_e0_busy", 32'(bus_busy), 32'd1);
    step();
    check("single_e1_rd", 32'(ftdi_rd_n), 32'd0);
    check("single_e1_tvalid", 32'(m_axis_tvalid), 32'd0);
    step();
    check("single_e2_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("single_e2_tdata", 32'(m_axis_tdata), 32'h45);
    check("single_e2_count", rx_count, 32'd1);
    step();
    check("single_ta_oe", 32'(ftdi_oe_n), 32'd1);
    check("single_ta_rd", 32'(ftdi_rd_n), 32'd1);
    check("single_ta_busy", 32'(bus_busy), 32'd1);
    step();
    check("single_idle_busy", 32'(bus_busy), 32'd0);
    check("single_rcv", 32'(rcv_cnt), 32'd1);

    // 16-byte burst at full rate
    start_burst(16, 8'h00);
    run_until_done(60, "burst");
    check("burst_count", rx_count, 32'd17);
    check("burst_span", 32'(last_cap - first_cap), 32'd15);
    check("burst_ovf", 32'(overflow_err), 32'd0);

    // Backpressure mid-burst
    start_burst(16, 8'h80);
    for (int i = 0; i < 40 && rcv_cnt < 4; i++) step();
    check("bp_rcv4", 32'(rcv_cnt), 32'd4);
    m_axis_tready = 1'b0;
    repeat (10) step();
    check("bp_rd_paused", 32'(ftdi_rd_n), 32'd1);
    check("bp_oe_held", 32'(ftdi_oe_n), 32'd0);
    check("bp_busy", 32'(bus_busy), 32'd1);
    check("bp_level", 32'(host_idx - rcv_cnt), 32'(DEPTH - 1));
    m_axis_tready = 1'b1;
    run_until_done(80, "bp");
    check("bp_count", rx_count, 32'd33);
    check("bp_ovf", 32'(overflow_err), 32'd0);

    // RXF# deasserts after 5 bytes
    start_burst(5, 8'h20);
    step_until_sent(5, 20, "rxf");
    check("rxf_last_oe", 32'(ftdi_oe_n), 32'd0);
    step();
    check("rxf_ta_oe", 32'(ftdi_oe_n), 32'd1);
    check("rxf_ta_rd", 32'(ftdi_rd_n), 32'd1);
    check("rxf_ta_busy", 32'(bus_busy), 32'd1);
    step();
    check("rxf_idle_busy", 32'(bus_busy), 32'd0);
    run_until_done(20, "rxf");
    check("rxf_count", rx_count, 32'd38);

    // Grant drops during READ
    start_burst(10, 8'h50);
    step_until_sent(3, 20, "grant");
    rx_grant = 1'b0;
    step();
    check("grant_exit_capture", 32'(host_idx), 32'd4);
    check("grant_exit_oe", 32'(ftdi_oe_n), 32'd1);
    check("grant_exit_rd", 32'(ftdi_rd_n), 32'd1);
    repeat (4) step();
    check("grant_no_capture", 32'(host_idx), 32'd4);
    check("grant_idle_busy", 32'(bus_busy), 32'd0);
    rx_grant = 1'b1;
    step();
    check("grant_restart_oe", 32'(ftdi_oe_n), 32'd0);
    run_until_done(60, "grant");
    check("grant_count", rx_count, 32'd48);

    // Asynchronous reset mid-burst
    start_burst(16, 8'h90);
    step_until_sent(5, 20, "rst");
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_oe", 32'(ftdi_oe_n), 32'd1);
    check("arst_rd", 32'(ftdi_rd_n), 32'd1);
    check("arst_busy", 32'(bus_busy), 32'd0);
    check("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
    host_avail = host_idx;
    host_drive();
    @(posedge ftdi_clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("arst_count", rx_count, 32'd0);
    check("arst_ovf", 32'(overflow_err), 32'd0);
    check("arst_tvalid_rel", 32'(m_axis_tvalid), 32'd0);
    step();
    check("arst_idle_oe", 32'(ftdi_oe_n), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
